// File: rtl/lcd_write_ctrl.sv
// Byte write controller for an HD44780-style LCD: accepts RS/DB bytes, fires the enable
// generator, then holds the bus through the pulse and execution wait. Option: LCD_POWERON_INIT_EN.
module lcd_write_ctrl #(
  parameter int PULSE_CYCLES     = 16,
  parameter int EXEC_CYCLES      = 2000,
  parameter int LONG_EXEC_CYCLES = 82000,
  parameter int POWERON_CYCLES   = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       lcd_start,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int MAX_A   = (PULSE_CYCLES > LONG_EXEC_CYCLES) ? PULSE_CYCLES : LONG_EXEC_CYCLES;
  localparam int MAX_B   = (MAX_A > EXEC_CYCLES) ? MAX_A : EXEC_CYCLES;
  localparam int MAX_ALL = (MAX_B > POWERON_CYCLES) ? MAX_B : POWERON_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYCLES);
`ifdef LCD_POWERON_INIT_EN
  localparam logic [CW-1:0] PWR_LD   = CW'(POWERON_CYCLES);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PULSE,
    ST_WAIT
`ifdef LCD_POWERON_INIT_EN
    , ST_POWER_WAIT
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;
`ifdef LCD_POWERON_INIT_EN
  logic          init_q, init_d;
  logic [1:0]    idx_q, idx_d;
`endif

  // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution time.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

`ifdef LCD_POWERON_INIT_EN
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    data_d    = data_q;
    long_d    = long_q;
`ifdef LCD_POWERON_INIT_EN
    init_d    = init_q;
    idx_d     = idx_q;
`endif
    in_ready  = (state_q == ST_IDLE) && !rst;
    lcd_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          rs_d    = in_rs;
          data_d  = in_data;
          long_d  = is_long(in_rs, in_data);
          state_d = ST_START;
        end
      end
      ST_START: begin
        lcd_start = 1'b1;
        cnt_d     = PULSE_LD;
        state_d   = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = long_q ? LONG_LD : EXEC_LD;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef LCD_POWERON_INIT_EN
          // During init, chain straight into the next ROM instruction.
          if (init_q) begin
            if (idx_q == 2'd3) begin
              init_d = 1'b0;
            end else begin
              idx_d   = idx_q + 2'd1;
              rs_d    = 1'b0;
              data_d  = init_byte(idx_q + 2'd1);
              long_d  = is_long(1'b0, init_byte(idx_q + 2'd1));
              state_d = ST_START;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef LCD_POWERON_INIT_EN
      ST_POWER_WAIT: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_byte(2'd0);
          long_d  = is_long(1'b0, init_byte(2'd0));
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef LCD_POWERON_INIT_EN
      state_q <= ST_POWER_WAIT;
      cnt_q   <= PWR_LD;
      init_q  <= 1'b1;
      idx_q   <= 2'd0;
`else
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`endif
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef LCD_POWERON_INIT_EN
      init_q  <= init_d;
      idx_q   <= idx_d;
`endif
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rw   = 1'b0;
  assign busy     = !in_ready;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Randomized bench for lcd_write_ctrl against a transaction-level timing model
// (accept -> start next cycle -> busy for 1+PULSE+EXEC/LONG cycles).
module tb_lcd_write_ctrl;

  localparam int PULSE = 16;
  localparam int EXEC  = 20;
  localparam int LONG  = 100;
  localparam int PWR   = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       lcd_start;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       busy;

  lcd_write_ctrl #(
    .PULSE_CYCLES(PULSE),
    .EXEC_CYCLES(EXEC),
    .LONG_EXEC_CYCLES(LONG),
    .POWERON_CYCLES(PWR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs(in_rs),
    .in_data(in_data),
    .lcd_start(lcd_start),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_data(lcd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_acc = 0;
  int starts[$];

  // Reference model: remaining busy cycles and the byte the bus should hold.
  int         m_rem = 0;
  logic       m_start = 1'b0;
  logic       m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic tick(input logic r, input logic v, input logic rs_i, input logic [7:0] d);
    logic lng;
    check("in_ready", 32'(in_ready), 32'((m_rem == 0) && !rst));
    check("busy", 32'(busy), 32'(!((m_rem == 0) && !rst)));
    check("lcd_start", 32'(lcd_start), 32'(m_start));
    check("lcd_rs", 32'(lcd_rs), 32'(m_rs));
    check("lcd_data", 32'(lcd_data), 32'(m_data));
    check("lcd_rw", 32'(lcd_rw), 32'(0));
    if (lcd_start) starts.push_back(cyc);
    rst = r; in_valid = v; in_rs = rs_i; in_data = d;
    @(posedge clk);
    cyc++;
    m_start = 1'b0;
    if (r) begin
      m_rem = 0; m_rs = 1'b0; m_data = 8'h00;
    end else if (m_rem == 0 && v) begin
      lng = !rs_i && (d >= 8'd1) && (d <= 8'd3);
      m_rem = 1 + PULSE + (lng ? LONG : EXEC);
      m_rs = rs_i; m_data = d; m_start = 1'b1;
      n_acc++;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    @(negedge clk);
  endtask

  // Offers a byte once ready, then returns how many cycles in_ready stayed low.
  task automatic send(input logic rs_i, input logic [7:0] d, output int span);
    int guard = 0;
    while (!in_ready && guard < 1000) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      guard++;
    end
    tick(1'b0, 1'b1, rs_i, d);
    span = 0;
    while (!in_ready && span < 1000) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom), 8'($urandom));
      span++;
    end
  endtask

`ifdef LCD_POWERON_INIT_EN
  task automatic init_check();
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [7:0] seen[$];
    int n = 0;
    int first = -1;
    int last = 0;
    int rs_bad = 0;
    rst = 1'b0; in_valid = 1'b1; in_rs = 1'b1; in_data = 8'hAA;
    while (!in_ready && n < 2000) begin
      @(posedge clk); @(negedge clk);
      n++; cyc++;
      if (lcd_start) begin
        if (first < 0) first = n;
        last = n;
        seen.push_back(lcd_data);
        if (lcd_rs) rs_bad++;
      end
    end
    check("s6_ready_seen", 32'(in_ready), 32'(1));
    check("s6_first_start_late", 32'(first >= PWR), 32'(1));
    check("s6_pulses", 32'(seen.size()), 32'(4));
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) check("s6_init_byte", 32'(seen[i]), 32'(rom[i]));
    check("s6_rs_zero", 32'(rs_bad), 32'(0));
    check("s6_long_tail", 32'(n - last), 32'(1 + PULSE + LONG));
    m_rem = 0; m_rs = 1'b0; m_data = 8'h01; m_start = 1'b0;
  endtask
`endif

  initial begin
    int span;
    int a0;
    int guard;
    logic r;
    logic [7:0] d;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tick(1'b1, 1'b1, 1'b1, 8'h55);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

`ifdef LCD_POWERON_INIT_EN
    init_check();
`endif

    // Plain data byte, then timing edges of the long flag.
    starts.delete();
    send(1'b1, 8'h41, span);
    check("s1_span", 32'(span), 32'(1 + PULSE + EXEC));
    check("s1_pulses", 32'(starts.size()), 32'(1));
    send(1'b0, 8'h01, span); check("s2_span_01", 32'(span), 32'(1 + PULSE + LONG));
    send(1'b0, 8'h02, span); check("s2_span_02", 32'(span), 32'(1 + PULSE + LONG));
    send(1'b0, 8'h03, span); check("s2_span_03", 32'(span), 32'(1 + PULSE + LONG));
    send(1'b0, 8'h04, span); check("s2_span_04", 32'(span), 32'(1 + PULSE + EXEC));
    send(1'b0, 8'h00, span); check("s2_span_00", 32'(span), 32'(1 + PULSE + EXEC));
    send(1'b1, 8'h01, span); check("s3_span_data01", 32'(span), 32'(1 + PULSE + EXEC));

    // Held in_valid gives back-to-back transfers.
    starts.delete();
    a0 = n_acc;
    guard = 0;
    while (n_acc == a0 && guard < 500) begin tick(1'b0, 1'b1, 1'b1, 8'h48); guard++; end
    while (n_acc == a0 + 1 && guard < 500) begin tick(1'b0, 1'b1, 1'b1, 8'h49); guard++; end
    while (!in_ready && guard < 500) begin tick(1'b0, 1'b0, 1'b0, 8'h00); guard++; end
    check("s4_pulses", 32'(starts.size()), 32'(2));
    if (starts.size() >= 2)
      check("s4_spacing", 32'(starts[1] - starts[0]), 32'(2 + PULSE + EXEC));

`ifndef LCD_POWERON_INIT_EN
    // Reset ten cycles into WAIT, with in_valid asserted alongside.
    tick(1'b0, 1'b1, 1'b1, 8'h7E);
    repeat (1 + PULSE + 10 - 1) tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 1'b1, 8'h33);
    check("s5_data_cleared", 32'(lcd_data), 32'(0));
    check("s5_start_low", 32'(lcd_start), 32'(0));
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    check("s5_ready_after", 32'(in_ready), 32'(1));
`endif

    for (int i = 0; i < 3000; i++) begin
`ifdef LCD_POWERON_INIT_EN
      r = 1'b0;
`else
      r = ($urandom_range(0, 199) == 0);
`endif
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      tick(r, 1'($urandom_range(0, 1)), 1'($urandom), d);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
